// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and its event FIFO.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchroniser, falling-edge detector and 11-bit frame receiver with watchdog.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   fall_q;
  logic                   bit_q;

  // Lines idle high, so the synchronisers reset to 1 to avoid a false edge after clr.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      fall_q      <= 1'b0;
      bit_q       <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      fall_q      <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
      bit_q       <= data_sync_q[SYNC_STAGES-1];
    end
  end

  rx_state_e       state_q;
  logic [2:0]      cnt_q;
  logic [7:0]      shift_q;
  logic            parity_q;
  logic [WD_W-1:0] wd_q;
  logic            valid_q;
  logic            err_q;
  logic            timeout;

  assign timeout = (state_q != ST_IDLE) && !fall_q && (wd_q == WD_LAST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      wd_q     <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;

      if (state_q == ST_IDLE || fall_q) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + 1'b1;
      end

      if (timeout) begin
        state_q <= ST_IDLE;
        shift_q <= '0;
        cnt_q   <= '0;
        err_q   <= 1'b1;
      end else if (fall_q) begin
        unique case (state_q)
          ST_IDLE: begin
            if (!bit_q) begin
              state_q <= ST_DATA;
              cnt_q   <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
          ST_DATA: begin
            shift_q <= {bit_q, shift_q[7:1]};
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_q <= bit_q;
            state_q  <= ST_STOP;
          end
          ST_STOP: begin
            if (bit_q && odd_parity_ok(shift_q, parity_q)) begin
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // The shift register holds its byte until the next start bit, so it is stable with valid_q.
  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver: E0/F0 prefix folding into key events buffered in a valid/ready FIFO.
module ps2_key_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  input  logic                        ev_ready,
  output logic                        ev_valid,
  output logic [7:0]                  ev_code,
  output logic                        ev_ext,
  output logic                        ev_brk,
  input  logic                        ovf_clr,
  output logic                        overflow,
  output logic                        frame_err,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam int               LVL_W    = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       rx_err;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .clr       (clr),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (rx_err)
  );

  logic       ext_q;
  logic       brk_q;
  logic       push;
  key_event_t push_ev;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    push         = 1'b0;
    push_ev      = '0;
    push_ev.ext  = ext_q;
    push_ev.brk  = brk_q;
    push_ev.code = byte_data;
    if (byte_valid && byte_data != PS2_EXT && byte_data != PS2_BRK) push = 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (rx_err || push) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (byte_valid) begin
      if (byte_data == PS2_EXT) ext_q <= 1'b1;
      if (byte_data == PS2_BRK) brk_q <= 1'b1;
    end
  end

  key_event_t       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [LVL_W-1:0] count_q;
  logic [LVL_W-1:0] count_d;
  logic [LVL_W-1:0] kept;
  logic             ev_valid_q;
  key_event_t       head_q;
  logic             overflow_q;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic             ovf_event;

  // kept excludes this cycle's push, so a freshly written entry is only presented next cycle.
  always_comb begin
    full      = (count_q == FULL_LVL);
    pop       = ev_valid_q & ev_ready;
    wr_en     = push & (~full | pop);
    ovf_event = push & full & ~pop;
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    kept      = count_q - LVL_W'(pop);
    count_d   = kept + LVL_W'(wr_en);
  end

  // NOTE: the storage array has no reset; ev_valid and the zeroed head register gate it.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_ev;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ev_valid_q <= 1'b0;
      head_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ev_valid_q <= (kept != '0);
      head_q     <= (kept != '0) ? mem_q[rd_ptr_d] : '0;
      if (ovf_event) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign ev_valid  = ev_valid_q;
  assign ev_code   = head_q.code;
  assign ev_ext    = head_q.ext;
  assign ev_brk    = head_q.brk;
  assign overflow  = overflow_q;
  assign frame_err = rx_err;
  assign level     = count_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo: prefix folding, errors, overflow, watchdog and mid-frame clear.
module tb_ps2_key_fifo;

  localparam int FIFO_DEPTH     = 4;
  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int HALF           = 20;
  localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1;

  logic             clk      = 1'b0;
  logic             clr      = 1'b1;
  logic             ps2_clk  = 1'b1;
  logic             ps2_data = 1'b1;
  logic             ev_ready = 1'b0;
  logic             ovf_clr  = 1'b0;
  logic             ev_valid;
  logic [7:0]       ev_code;
  logic             ev_ext;
  logic             ev_brk;
  logic             overflow;
  logic             frame_err;
  logic [LVL_W-1:0] level;

  int n_vec    = 0;
  int n_bad    = 0;
  int err_cnt  = 0;
  int err_base = 0;

  ps2_key_fifo #(
    .FIFO_DEPTH    (FIFO_DEPTH),
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_code  (ev_code),
    .ev_ext   (ev_ext),
    .ev_brk   (ev_brk),
    .ovf_clr  (ovf_clr),
    .overflow (overflow),
    .frame_err(frame_err),
    .level    (level)
  );

  always #5 clk = ~clk;

  // Counts high cycles of frame_err, so a stretched pulse shows up as an extra error.
  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ev(input string tag, input logic [7:0] code, input logic ext,
                          input logic brk);
    check({tag, "_valid"}, 32'(ev_valid), 32'd1);
    check({tag, "_code"}, 32'(ev_code), 32'(code));
    check({tag, "_ext"}, 32'(ev_ext), 32'(ext));
    check({tag, "_brk"}, 32'(ev_brk), 32'(brk));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    idle(HALF);
    ps2_clk = 1'b0;
    idle(HALF);
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of the frame for byte b (start, data LSB first, parity, stop).
  task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] frame;
    frame = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(frame[i]);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
  endtask

  task automatic pop_one;
    @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  initial begin
    idle(3);
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_code", 32'(ev_code), 32'd0);
    check("rst_extbrk", 32'({ev_ext, ev_brk}), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    clr = 1'b0;
    idle(5);

    send_frame(8'h1C);
    idle(5);
    check_ev("t1", 8'h1C, 1'b0, 1'b0);
    check("t1_level", 32'(level), 32'd1);
    pop_one();
    check("t1_level_pop", 32'(level), 32'd0);
    check("t1_valid_pop", 32'(ev_valid), 32'd0);

    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    idle(5);
    check("t2_level1", 32'(level), 32'd1);
    check_ev("t2_e0f075", 8'h75, 1'b1, 1'b1);
    send_frame(8'h75);
    idle(5);
    check("t2_level2", 32'(level), 32'd2);
    pop_one();
    check_ev("t2_plain75", 8'h75, 1'b0, 1'b0);
    pop_one();
    check("t2_level0", 32'(level), 32'd0);

    err_base = err_cnt;
    send_frame(8'hF0);
    send_bits(8'h1C, 1'b1, 11);
    send_frame(8'h1C);
    idle(5);
    check("t3_err_pulses", 32'(err_cnt - err_base), 32'd1);
    check("t3_level", 32'(level), 32'd1);
    check_ev("t3_brk_cleared", 8'h1C, 1'b0, 1'b0);
    pop_one();

    send_frame(8'h16);
    send_frame(8'h1E);
    send_frame(8'h26);
    send_frame(8'h25);
    send_frame(8'h2E);
    idle(5);
    check("t4_level_full", 32'(level), 32'd4);
    check("t4_overflow", 32'(overflow), 32'd1);
    check_ev("t4_pop0", 8'h16, 1'b0, 1'b0);
    pop_one();
    check_ev("t4_pop1", 8'h1E, 1'b0, 1'b0);
    pop_one();
    check_ev("t4_pop2", 8'h26, 1'b0, 1'b0);
    pop_one();
    check_ev("t4_pop3", 8'h25, 1'b0, 1'b0);
    pop_one();
    check("t4_empty", 32'(ev_valid), 32'd0);
    check("t4_level0", 32'(level), 32'd0);
    check("t4_ovf_sticky", 32'(overflow), 32'd1);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t4_ovf_clr", 32'(overflow), 32'd0);

    err_base = err_cnt;
    send_bits(8'h1C, 1'b0, 5);
    check("t5_no_early_err", 32'(err_cnt - err_base), 32'd0);
    idle(TIMEOUT_CYCLES + 50);
    check("t5_timeout_err", 32'(err_cnt - err_base), 32'd1);
    send_frame(8'h1C);
    idle(5);
    check("t5_level", 32'(level), 32'd1);
    check_ev("t5_after_to", 8'h1C, 1'b0, 1'b0);
    pop_one();

    send_frame(8'h16);
    send_frame(8'h1E);
    idle(5);
    check("t6_level2", 32'(level), 32'd2);
    send_bits(8'h26, 1'b0, 3);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("t6_clr_valid", 32'(ev_valid), 32'd0);
    check("t6_clr_level", 32'(level), 32'd0);
    check("t6_clr_code", 32'({ev_code, ev_ext, ev_brk}), 32'd0);
    check("t6_clr_ovf_err", 32'({overflow, frame_err}), 32'd0);
    clr = 1'b0;
    idle(5);
    send_frame(8'h1C);
    idle(5);
    check("t6_level1", 32'(level), 32'd1);
    check_ev("t6_after_clr", 8'h1C, 1'b0, 1'b0);
    pop_one();
    check("t6_level0", 32'(level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
